rotor_inv_table: RTL and testbench
==================================

// Module: rotor_inv_table
// PURPOSE
//  Reverse-path companion to the rotor B table register. Snoops the same serial load stream
//  (6-bit codes shifted in one per beat) and builds the inverse permutation inv[code] = position.
//  Serves the return path (post-reflector) through a 1-cycle registered lookup port.
//  Beat k (k = 0..63) of a fill lands at forward position k, so inv[code_in_buf] <= k.
// PARAMETERS
//  TABLE_ID   2'b01  table_idx_buf value that selects this rotor's load stream
//  DEPTH      64     entries per table; fixed, equal to 2**6 (code width 6)
// PORTS
//  clk                input   1  rising-edge clock, sole clock domain
//  rst                input   1  synchronous, active-high reset
//  table_idx_buf      input   2  table selector of the load stream
//  load_buf           input   1  load beat strobe
//  code_in_buf        input   6  code carried by the load beat
//  lookup_valid       input   1  inverse lookup request, single-cycle
//  lookup_code        input   6  forward-table value to invert
//  lookup_data        output  6  inverse position (registered)
//  lookup_data_valid  output  1  response strobe, exactly 1 cycle after lookup_valid
//  lookup_miss        output  1  response produced while table not READY (lookup_data = 0)
//  table_ready        output  1  high while state = READY
//  load_cnt           output  6  beats accepted in the current fill
//  dup_err            output  1  duplicate code seen in current/last fill (see CONFIGURATION)
// BEHAVIOUR
//  - beat = load_buf && (table_idx_buf == TABLE_ID). Other table_idx values are ignored entirely.
//  - Reset: state EMPTY, load_cnt 0, lookup_data 0, lookup_data_valid 0, lookup_miss 0,
//    table_ready 0, dup_err 0. inv[] contents are not reset and are don't-care until READY.
//  - FSM:  EMPTY --beat--> FILL;
//          FILL  --beat with load_cnt==63--> READY (load_cnt wraps to 0);
//          READY --beat--> FILL (new fill; old table invalid from the next cycle).
//    No other transitions. rst in any state, including mid-fill, returns to EMPTY;
//    a partial fill is discarded.
//  - Beat write: inv[code_in_buf] <= load_cnt; load_cnt <= load_cnt + 1 (mod 64).
//    A beat in EMPTY or READY writes at position 0 and sets load_cnt to 1.
//  - Lookup: on lookup_valid in cycle t, lookup_data_valid = 1 in cycle t+1.
//    If state(t) == READY: lookup_data = inv[lookup_code], lookup_miss = 0.
//    Else: lookup_data = 0, lookup_miss = 1.
//    When no request is made, lookup_data_valid and lookup_miss are 0 and lookup_data holds.
//  - Simultaneous beat and lookup in READY: read-before-write. The response uses the
//    pre-write table and lookup_miss = 0. Lookups from t+1 onward miss until the new fill completes.
//  - Throughput: one beat and one lookup per cycle, no back-pressure.
// CONFIGURATION
//  - ROTOR_INV_PERM_CHECK_EN defined: a 64-bit seen bitmap is cleared by reset.
//    A beat that starts a new fill clears the bitmap and then marks its own code.
//    A beat whose code is already marked sets dup_err in the next cycle.
//    dup_err is sticky until reset or the start of the next fill.
//    table_ready still asserts on the 64th beat regardless of dup_err.
//  - ROTOR_INV_PERM_CHECK_EN undefined: no bitmap is built and dup_err is tied to 0.
// TESTING
//  1. Fill with codes 0..63 in order, then lookup 17 -> lookup_data 17, miss 0.
//     table_ready rises the cycle after the 64th beat.
//  2. Fill with code 63-k at beat k, then lookup 5 -> lookup_data 58.
//     Lookup 0 -> 63, returned 1 cycle after request.
//  3. Lookup during FILL (load_cnt = 20) -> lookup_data_valid 1, lookup_miss 1, lookup_data 0.
//  4. Beats with table_idx_buf = 2'b10 interleaved into a fill -> ignored;
//     load_cnt counts only TABLE_ID beats.
//  5. READY table, new beat + lookup 9 in the same cycle -> old inv[9] returned, miss 0.
//     Next-cycle lookup -> miss 1.
//  6. rst after 30 beats -> EMPTY, load_cnt 0.
//     With PERM_CHECK_EN, code 12 sent twice in a fill -> dup_err 1 until the next fill starts.

Source files
------------

// File: rtl/rotor_inv_table.sv
// Inverse permutation table for the rotor B return path, built from the shared load stream.
// Optional duplicate-code detection is enabled by defining ROTOR_INV_PERM_CHECK_EN.
module rotor_inv_table #(
  parameter logic [1:0] TABLE_ID = 2'b01,
  parameter int         DEPTH    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] table_idx_buf,
  input  logic       load_buf,
  input  logic [5:0] code_in_buf,
  input  logic       lookup_valid,
  input  logic [5:0] lookup_code,
  output logic [5:0] lookup_data,
  output logic       lookup_data_valid,
  output logic       lookup_miss,
  output logic       table_ready,
  output logic [5:0] load_cnt,
  output logic       dup_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t     state;
  logic       beat;
  logic       start;
  logic [5:0] wr_pos;
  logic [5:0] inv [DEPTH];

  assign beat   = load_buf && (table_idx_buf == TABLE_ID);
  assign start  = (state != FILL);
  assign wr_pos = start ? 6'd0 : load_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= EMPTY;
      load_cnt          <= 6'd0;
      table_ready       <= 1'b0;
      lookup_data       <= 6'd0;
      lookup_data_valid <= 1'b0;
      lookup_miss       <= 1'b0;
    end else begin
      lookup_data_valid <= lookup_valid;
      lookup_miss       <= lookup_valid && (state != READY);
      // read sees the pre-write table when a beat lands in the same cycle
      if (lookup_valid)
        lookup_data <= (state == READY) ? inv[lookup_code] : 6'd0;
      if (beat) begin
        unique case (state)
          EMPTY, READY: begin
            state       <= FILL;
            load_cnt    <= 6'd1;
            table_ready <= 1'b0;
          end
          FILL: begin
            if (load_cnt == 6'd63) begin
              state       <= READY;
              load_cnt    <= 6'd0;
              table_ready <= 1'b1;
            end else begin
              load_cnt <= load_cnt + 6'd1;
            end
          end
          default: begin
            state       <= EMPTY;
            load_cnt    <= 6'd0;
            table_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat)
      inv[code_in_buf] <= wr_pos;
  end

`ifdef ROTOR_INV_PERM_CHECK_EN
  logic [DEPTH-1:0] seen;
  logic [DEPTH-1:0] one_hot;

  assign one_hot = {{(DEPTH-1){1'b0}}, 1'b1} << code_in_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen    <= '0;
      dup_err <= 1'b0;
    end else if (beat) begin
      if (start) begin
        seen    <= one_hot;
        dup_err <= 1'b0;
      end else begin
        seen <= seen | one_hot;
        if (seen[code_in_buf])
          dup_err <= 1'b1;
      end
    end
  end
`else
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_rotor_inv_table.sv
// Scoreboard bench for rotor_inv_table: driver queues expected lookups,
// a negedge monitor pops and compares each response.
module tb_rotor_inv_table;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] table_idx_buf;
  logic       load_buf;
  logic [5:0] code_in_buf;
  logic       lookup_valid;
  logic [5:0] lookup_code;
  logic [5:0] lookup_data;
  logic       lookup_data_valid;
  logic       lookup_miss;
  logic       table_ready;
  logic [5:0] load_cnt;
  logic       dup_err;

`ifdef ROTOR_INV_PERM_CHECK_EN
  localparam logic DUP_EN = 1'b1;
`else
  localparam logic DUP_EN = 1'b0;
`endif

  typedef struct {
    logic [5:0] d;
    logic       m;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  rotor_inv_table dut (
    .clk              (clk),
    .rst              (rst),
    .table_idx_buf    (table_idx_buf),
    .load_buf         (load_buf),
    .code_in_buf      (code_in_buf),
    .lookup_valid     (lookup_valid),
    .lookup_code      (lookup_code),
    .lookup_data      (lookup_data),
    .lookup_data_valid(lookup_data_valid),
    .lookup_miss      (lookup_miss),
    .table_ready      (table_ready),
    .load_cnt         (load_cnt),
    .dup_err          (dup_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    load_buf      = 1'b0;
    lookup_valid  = 1'b0;
    table_idx_buf = 2'b01;
  endtask

  task automatic beat(input logic [5:0] c);
    code_in_buf = c;
    load_buf    = 1'b1;
    step();
  endtask

  task automatic lookup(input logic [5:0] c, input logic [5:0] d,
                        input logic m);
    exp_t e;
    lookup_code  = c;
    lookup_valid = 1'b1;
    e.d = d;
    e.m = m;
    e.c = cyc + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (lookup_data_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_data", int'(lookup_data), int'(e.d));
        chk("resp_miss", int'(lookup_miss), int'(e.m));
        chk("resp_latency", cyc, e.c);
      end
    end else if (lookup_miss) begin
      chk("miss_without_valid", 1, 0);
    end
  end

  initial begin
    rst           = 1'b1;
    table_idx_buf = 2'b01;
    load_buf      = 1'b0;
    code_in_buf   = 6'd0;
    lookup_valid  = 1'b0;
    lookup_code   = 6'd0;
    step();
    step();
    chk("rst_ready", int'(table_ready), 0);
    chk("rst_load_cnt", int'(load_cnt), 0);
    chk("rst_data", int'(lookup_data), 0);
    chk("rst_valid", int'(lookup_data_valid), 0);
    chk("rst_miss", int'(lookup_miss), 0);
    chk("rst_dup", int'(dup_err), 0);
    rst = 1'b0;

    lookup(6'd4, 6'd0, 1'b1);
    step();

    // identity fill with a foreign-table beat slipped in
    for (int k = 0; k < 64; k++) begin
      if (k == 20) begin
        chk("fill_cnt20", int'(load_cnt), 20);
        lookup(6'd3, 6'd0, 1'b1);
      end
      beat(6'(k));
      if (k == 10) begin
        table_idx_buf = 2'b10;
        code_in_buf   = 6'd5;
        load_buf      = 1'b1;
        step();
        chk("foreign_ignored", int'(load_cnt), 11);
      end
      if (k == 62) chk("ready_before_last", int'(table_ready), 0);
    end
    chk("ready_after_fill", int'(table_ready), 1);
    chk("cnt_wrap", int'(load_cnt), 0);
    lookup(6'd17, 6'd17, 1'b0);
    step();
    lookup(6'd5, 6'd5, 1'b0);
    step();

    // reverse fill; first beat collides with a lookup
    lookup(6'd9, 6'd9, 1'b0);
    beat(6'd63);
    chk("refill_ready", int'(table_ready), 0);
    lookup(6'd1, 6'd0, 1'b1);
    beat(6'd62);
    for (int k = 2; k < 64; k++) beat(6'(63 - k));
    chk("rev_ready", int'(table_ready), 1);
    lookup(6'd5, 6'd58, 1'b0);
    step();
    lookup(6'd0, 6'd63, 1'b0);
    step();
    lookup(6'd63, 6'd0, 1'b0);
    step();
    step();

    // partial fill aborted by reset
    for (int k = 0; k < 30; k++) beat(6'(k));
    chk("partial_cnt", int'(load_cnt), 30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_cnt", int'(load_cnt), 0);
    chk("abort_ready", int'(table_ready), 0);
    lookup(6'd7, 6'd0, 1'b1);
    step();

    // code 12 repeated at beat 20
    for (int k = 0; k < 64; k++) begin
      beat((k == 20) ? 6'd12 : 6'(k));
      if (k == 19) chk("dup_before", int'(dup_err), 0);
      if (k == 20) chk("dup_set", int'(dup_err), int'(DUP_EN));
    end
    chk("dup_ready", int'(table_ready), 1);
    chk("dup_sticky", int'(dup_err), int'(DUP_EN));
    lookup(6'd12, 6'd20, 1'b0);
    step();
    beat(6'd0);
    chk("dup_clear", int'(dup_err), 0);
    chk("newfill_cnt", int'(load_cnt), 1);

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
